fetch_queue: RTL and testbench

- Instruction-fetch front end that drives instruction memory and buffers returned instructions, with their PCs, for the decode stage.
- Issues sequential word-aligned fetches and holds up to DEPTH instructions.
- Presents a valid/ready interface to decode, so decode stalls never drop or duplicate instructions.
- Accepts a redirect (branch/jump target) that flushes all buffered and in-flight work.

---
 rtl/fetch_queue.sv | 121 ++++++++++++
 tb/tb_fetch_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction-fetch front end. Issues sequential word-aligned fetches to a
//   single-cycle instruction memory and buffers the returned instructions,
//   together with their PCs, in a small circular queue for the decode stage.
//   A redirect flushes every buffered and in-flight fetch and restarts at the
//   new target.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous reset, active high
//   imem_re_o      fetch request to instruction memory this cycle
//   imem_addr_o    fetch address (valid when imem_re_o=1)
//   imem_instr_i   instruction data, valid exactly one cycle after a request
//   redirect_i     flush and restart fetch at redirect_pc_i
//   redirect_pc_i  new fetch address, bits [1:0] ignored
//   instr_valid_o  queue head valid toward decode
//   instr_o        queue head instruction
//   pc_o           PC of the queue head instruction
//   instr_ready_i  decode accepts the head this cycle
//   count_o        number of entries currently held
//
// Handshake: an instruction moves to decode in exactly the cycles where
// instr_valid_o && instr_ready_i at the rising edge. The head, instr_o and
// pc_o hold steady while valid is high and ready is low. valid does not
// depend on ready.

module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       imem_re_o,
   output logic [31:0]                imem_addr_o,
   input  logic [31:0]                imem_instr_i,
   input  logic                       redirect_i,
   input  logic [31:0]                redirect_pc_i,
   output logic                       instr_valid_o,
   output logic [31:0]                instr_o,
   output logic [31:0]                pc_o,
   input  logic                       instr_ready_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   logic [31:0]   fpc;
   logic          inflight;
   logic [31:0]   inflight_pc;
   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic [CW:0]   occupancy;
   logic          issue;
   logic          push;
   logic          pop;

   // Reserve a slot for the outstanding request so its response can always
   // be pushed. A same-cycle pop is deliberately not credited, which keeps
   // imem_re_o independent of instr_ready_i.
   assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign issue     = !rst && !redirect_i && (occupancy < DEPTH_W);

   // A response returning during a redirect or reset belongs to the flushed
   // stream and is dropped.
   assign push      = inflight && !redirect_i && !rst;

   assign instr_valid_o = !rst && !redirect_i && (count != '0);
   assign pop           = instr_valid_o && instr_ready_i;

   assign imem_re_o   = issue;
   assign imem_addr_o = rst ? 32'h0 : fpc;
   assign instr_o     = rst ? 32'h0 : instr_mem[rd_ptr];
   assign pc_o        = rst ? 32'h0 : pc_mem[rd_ptr];
   assign count_o     = rst ? '0 : count;

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc         <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= 32'h0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else if (redirect_i) begin
         fpc      <= {redirect_pc_i[31:2], 2'b00};
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            fpc         <= fpc + 32'd4;
            inflight_pc <= fpc;
         end
         // DEPTH is a power of two, so the pointers wrap naturally.
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; count gates whether the head is meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= inflight_pc;
         instr_mem[wr_ptr] <= imem_instr_i;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Directed bench for fetch_queue (DEPTH=4, RESET_PC=0). The memory model
//   answers each request one cycle later with addr ^ 32'hA5A5_0000.
//   Each step() starts a new cycle: inputs change 1 time unit after the
//   rising edge and outputs are sampled 1 unit later.

module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_re_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_instr_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        instr_ready_i;
   logic [2:0]  count_o;

   int n_tests = 0;
   int n_fail  = 0;
   int n_pops  = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp_pc;

   fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_re_o     (imem_re_o),
      .imem_addr_o   (imem_addr_o),
      .imem_instr_i  (imem_instr_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .instr_ready_i (instr_ready_i),
      .count_o       (count_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   always @(posedge clk) begin
      imem_instr_i <= imem_re_o ? (imem_addr_o ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver / checker tasks ----------------
   task automatic step(input logic r, input logic rd, input logic rdr,
                       input logic [31:0] rp);
      @(posedge clk);
      #1;
      rst           = r;
      instr_ready_i = rd;
      redirect_i    = rdr;
      redirect_pc_i = rp;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst           = 1'b1;
      instr_ready_i = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;

      // Reset outputs
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("rst_re",    imem_re_o,     32'h0);
      chk("rst_valid", instr_valid_o, 32'h0);
      chk("rst_count", count_o,       32'h0);
      chk("rst_addr",  imem_addr_o,   32'h0);
      chk("rst_pc",    pc_o,          32'h0);
      chk("rst_instr", instr_o,       32'h0);

      // Streaming with ready high: request every cycle, head 2 cycles behind
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         chk("str_re",   imem_re_o,   32'h1);
         chk("str_addr", imem_addr_o, 32'(4 * k));
         if (k < 2) begin
            chk("str_valid0", instr_valid_o, 32'h0);
         end else begin
            chk("str_valid", instr_valid_o, 32'h1);
            chk("str_pc",    pc_o,          32'(4 * (k - 2)));
            chk("str_instr", instr_o,       32'(4 * (k - 2)) ^ 32'hA5A5_0000);
            chk("str_count", count_o,       32'h1);
         end
      end

      // Decode stalled from reset: exactly four requests, then saturate
      step(1'b1, 1'b0, 1'b0, 32'h0);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0);
         if (k < 4) begin
            chk("full_re",   imem_re_o,   32'h1);
            chk("full_addr", imem_addr_o, 32'(4 * k));
         end else begin
            chk("full_re_stop", imem_re_o, 32'h0);
         end
      end
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("full_count", count_o,       32'h4);
      chk("full_re_0",  imem_re_o,     32'h0);
      chk("full_valid", instr_valid_o, 32'h1);
      chk("full_pc",    pc_o,          32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("hold_pc",    pc_o,          32'h0);
      chk("hold_instr", instr_o,       32'hA5A5_0000);
      chk("hold_re",    imem_re_o,     32'h0);
      // Release: no credit for the first pop, then fetch resumes at 16
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         chk("drain_pc", pc_o, 32'(4 * k));
         if (k == 0) begin
            chk("drain_re0",   imem_re_o, 32'h0);
            chk("drain_count", count_o,   32'h4);
         end else begin
            chk("drain_re",   imem_re_o,   32'h1);
            chk("drain_addr", imem_addr_o, 32'(4 * k + 12));
         end
      end

      // Redirect with 2 queued and 1 in flight
      step(1'b1, 1'b0, 1'b0, 32'h0);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b1, 32'h0000_0103);
      chk("rdr_pre_count", count_o,       32'h2);
      chk("rdr_T_valid",   instr_valid_o, 32'h0);
      chk("rdr_T_re",      imem_re_o,     32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("rdr_T1_re",    imem_re_o,     32'h1);
      chk("rdr_T1_addr",  imem_addr_o,   32'h0000_0100);
      chk("rdr_T1_count", count_o,       32'h0);
      chk("rdr_T1_valid", instr_valid_o, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("rdr_T2_addr",  imem_addr_o,   32'h0000_0104);
      chk("rdr_T2_valid", instr_valid_o, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("rdr_T3_valid", instr_valid_o, 32'h1);
      chk("rdr_T3_pc",    pc_o,          32'h0000_0100);
      chk("rdr_T3_instr", instr_o,       32'hA5A5_0100);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("rdr_T4_pc",    pc_o,          32'h0000_0104);

      // Back-to-back redirects: last one wins
      step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
      chk("b2b_T_re",     imem_re_o,     32'h0);
      chk("b2b_T_valid",  instr_valid_o, 32'h0);
      step(1'b0, 1'b1, 1'b1, 32'h0000_0300);
      chk("b2b_T1_re",    imem_re_o,     32'h0);
      chk("b2b_T1_valid", instr_valid_o, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("b2b_T2_addr",  imem_addr_o,   32'h0000_0300);
      chk("b2b_T2_count", count_o,       32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("b2b_T3_addr",  imem_addr_o,   32'h0000_0304);
      chk("b2b_T3_valid", instr_valid_o, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("b2b_T4_valid", instr_valid_o, 32'h1);
      chk("b2b_T4_pc",    pc_o,          32'h0000_0300);
      chk("b2b_T4_instr", instr_o,       32'hA5A5_0300);

      // Fetch PC wraps modulo 2^32; low target bits are ignored
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("wrap_addr1", imem_addr_o, 32'h0000_0000);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("wrap_pc0",    pc_o,    32'hFFFF_FFFC);
      chk("wrap_instr0", instr_o, 32'h5A5A_FFFC);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("wrap_pc1",    pc_o,    32'h0000_0000);

      // Reset with 3 queued and 1 in flight
      step(1'b1, 1'b0, 1'b0, 32'h0);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("mrst_re",    imem_re_o,     32'h0);
      chk("mrst_count", count_o,       32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("mrst_R_count", count_o,       32'h0);
      chk("mrst_R_valid", instr_valid_o, 32'h0);
      chk("mrst_R_addr",  imem_addr_o,   32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("mrst_R1_valid", instr_valid_o, 32'h0);
      chk("mrst_R1_count", count_o,       32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("mrst_R2_pc",    pc_o,          32'h0);
      chk("mrst_R2_count", count_o,       32'h1);

      // Reset and redirect together: reset wins
      step(1'b1, 1'b0, 1'b1, 32'h0000_0500);
      chk("rr_re", imem_re_o, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("rr_addr", imem_addr_o, 32'h0);
      chk("rr_re1",  imem_re_o,   32'h1);

      // Random ready toggling: pops must follow 0,4,8,... with no gaps
      for (int i = 0; i < 1000; i++) exp_q.push_back(32'(4 * i));
      step(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 1000; i++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
         chk("rnd_count_max", 32'(count_o <= 3'd4), 32'h1);
         if (instr_valid_o && instr_ready_i) begin
            exp_pc = exp_q.pop_front();
            chk("rnd_pc",    pc_o,    exp_pc);
            chk("rnd_instr", instr_o, exp_pc ^ 32'hA5A5_0000);
            n_pops++;
         end
      end
      chk("rnd_pops_min", 32'(n_pops >= 200), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
